// File: rtl/sched_pkg.sv
// Shared types, constants and helpers for the tick slot scheduler.
package sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    localparam int CNT_W     = 16;
    localparam int MAX_PKT_W = 64;

    // Slot that a packet with delay d lands in, relative to the draining slot.
    function automatic int unsigned slot_of(input int unsigned ptr,
                                            input int unsigned d,
                                            input int unsigned num_slots);
        return (ptr + d) % num_slots;
    endfunction

    // Low payload_w bits of a packet.
    function automatic logic [MAX_PKT_W-1:0] pkt_payload(input logic [MAX_PKT_W-1:0] pkt,
                                                         input int unsigned payload_w);
        return pkt & ((64'd1 << payload_w) - 64'd1);
    endfunction

    // Delay field, sitting above the payload.
    function automatic logic [MAX_PKT_W-1:0] pkt_delay(input logic [MAX_PKT_W-1:0] pkt,
                                                       input int unsigned payload_w);
        return pkt >> payload_w;
    endfunction

    // Saturating add for the drop counters.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sched_slot_fifo.sv
// Synchronous slot FIFO with a one-cycle flush that discards all entries.
module sched_slot_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_wr = wr_en && (r_count != CW'(DEPTH));
    assign w_do_rd = rd_en && (r_count != CW'(0));
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage array; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the slot in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + A_ONE;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + A_ONE;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tick_slot_scheduler.sv
// Tick slot scheduler: router packets are parked in NUM_SLOTS rotating slot
// FIFOs by delay field and the current tick's slot is streamed to the neuron
// controller through a registered valid/ready stage.
// Optional drop statistics are built when SCHED_STATS_EN is defined.
module tick_slot_scheduler
    import sched_pkg::*;
#(
    parameter  int PKT_SIZE   = 32,
    parameter  int NUM_SLOTS  = 4,
    parameter  int SLOT_DEPTH = 256,
    localparam int DELAY_W    = $clog2(NUM_SLOTS),
    localparam int PAYLOAD_W  = PKT_SIZE - DELAY_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [PKT_SIZE-1:0]  in_pkt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DELAY_W-1:0]   tick_ptr,
    output logic [CNT_W-1:0]     drop_late_cnt,
    output logic [CNT_W-1:0]     drop_ovf_cnt
);

    localparam int CW = $clog2(SLOT_DEPTH) + 1;

    logic [DELAY_W-1:0]   r_tick_ptr;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_out_payload;
    sched_state_e         r_state;
    sched_state_e         w_state_nxt;

    logic [DELAY_W-1:0]   w_delay;
    logic [PAYLOAD_W-1:0] w_payload;
    logic [DELAY_W-1:0]   w_target;
    logic                 w_accept;
    logic                 w_target_full;
    logic                 w_wr_ok;
    logic [CW-1:0]        w_cur_count;
    logic                 w_cur_empty;
    logic                 w_pop;
    logic                 w_out_valid_nxt;

    logic [CW-1:0]        w_count   [NUM_SLOTS];
    logic [PAYLOAD_W-1:0] w_rd_data [NUM_SLOTS];
    logic                 w_wr_en   [NUM_SLOTS];
    logic                 w_rd_en   [NUM_SLOTS];
    logic                 w_flush   [NUM_SLOTS];

    assign w_delay   = DELAY_W'(pkt_delay(MAX_PKT_W'(in_pkt), PAYLOAD_W));
    assign w_payload = PAYLOAD_W'(pkt_payload(MAX_PKT_W'(in_pkt), PAYLOAD_W));
    assign w_target  = DELAY_W'(slot_of(32'(r_tick_ptr), 32'(w_delay), NUM_SLOTS));

    assign w_accept      = in_valid && r_in_ready;
    assign w_target_full = (w_count[w_target] == CW'(SLOT_DEPTH));
    // d==0 would land in the slot being drained, so it is dropped like an overflow.
    assign w_wr_ok       = w_accept && (w_delay != DELAY_W'(0)) && !w_target_full;

    assign w_cur_count = w_count[r_tick_ptr];
    assign w_cur_empty = (w_cur_count == CW'(0));
    // Popping is gated by the registered DRAIN state, which gives the freshly
    // rotated slot one settle cycle before its first entry is issued.
    assign w_pop           = (r_state == DRAIN) && !w_cur_empty && (!r_out_valid || out_ready);
    assign w_out_valid_nxt = w_pop || (r_out_valid && !out_ready);

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            assign w_wr_en[g] = w_wr_ok && (w_target == DELAY_W'(g));
            assign w_rd_en[g] = w_pop && (r_tick_ptr == DELAY_W'(g));
            assign w_flush[g] = tick && (r_tick_ptr == DELAY_W'(g));

            sched_slot_fifo #(
                .DEPTH (SLOT_DEPTH),
                .WIDTH (PAYLOAD_W)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (w_flush[g]),
                .wr_en   (w_wr_en[g]),
                .wr_data (w_payload),
                .rd_en   (w_rd_en[g]),
                .rd_data (w_rd_data[g]),
                .count   (w_count[g])
            );
        end
    endgenerate

    // Tick pointer rotation and input-ready generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_ptr <= {DELAY_W{1'b0}};
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            if (tick) begin
                r_tick_ptr <= r_tick_ptr + DELAY_W'(1);
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state: busy while the current slot has data or output is held.
    always_comb begin
        w_state_nxt = r_state;
        if (tick) begin
            if (w_out_valid_nxt) w_state_nxt = DRAIN;
            else                 w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_cur_empty || r_out_valid) w_state_nxt = DRAIN;
                    else                             w_state_nxt = IDLE;
                end
                DRAIN: begin
                    if (!w_cur_empty || w_out_valid_nxt) w_state_nxt = DRAIN;
                    else                                 w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // One-entry output skid register; a held entry survives tick boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_payload <= {PAYLOAD_W{1'b0}};
        end else if (w_pop) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= w_rd_data[r_tick_ptr];
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end else begin
            r_out_valid   <= r_out_valid;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_payload = r_out_payload;
    assign tick_ptr    = r_tick_ptr;

`ifdef SCHED_STATS_EN
    logic [CNT_W-1:0] r_drop_late_cnt;
    logic [CNT_W-1:0] r_drop_ovf_cnt;
    logic [CNT_W-1:0] w_late_add;

    // The entry popped into the output register at the tick edge is not lost.
    assign w_late_add = CNT_W'(w_cur_count) - CNT_W'(w_pop);

    // Saturating drop counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_late_cnt <= {CNT_W{1'b0}};
            r_drop_ovf_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (tick) begin
                r_drop_late_cnt <= sat_add(r_drop_late_cnt, w_late_add);
            end
            if (w_accept && !w_wr_ok) begin
                r_drop_ovf_cnt <= sat_add(r_drop_ovf_cnt, 16'd1);
            end
        end
    end

    assign drop_late_cnt = r_drop_late_cnt;
    assign drop_ovf_cnt  = r_drop_ovf_cnt;
`else
    assign drop_late_cnt = 16'd0;
    assign drop_ovf_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_tick_slot_scheduler.sv
// Self-checking bench for tick_slot_scheduler: directed cases plus a
// randomized phase scored against a queue-per-slot reference model.
module tb_tick_slot_scheduler;

    localparam int NS = 4;
    localparam int SD = 256;
    localparam int PW = 30;
`ifdef SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [31:0]   in_pkt = 32'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] out_payload;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    tick_ptr;
    logic [15:0]   drop_late_cnt;
    logic [15:0]   drop_ovf_cnt;

    tick_slot_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .in_pkt        (in_pkt),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_payload   (out_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .tick_ptr      (tick_ptr),
        .drop_late_cnt (drop_late_cnt),
        .drop_ovf_cnt  (drop_ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: one queue of pending payloads per slot.
    logic [PW-1:0] exp_q [NS][$];
    int exp_ptr = 0;
    int exp_ovf = 0;
    int exp_late = 0;
    bit sb_on = 1'b0;
    bit tick_chk = 1'b0;
    int hs_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        if (!STATS) return 32'd0;
        return (v > 65535) ? 32'd65535 : 32'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) exp_q[i].delete();
        exp_ptr = 0;
        exp_ovf = 0;
        exp_late = 0;
    endtask

    // One clock cycle: drive inputs, score the handshake, update model.
    task automatic cycle(input bit v, input logic [1:0] d, input logic [PW-1:0] pl,
                         input bit tk, input bit rdy);
        int tgt;
        in_valid  = v;
        in_pkt    = {d, pl};
        tick      = tk;
        out_ready = rdy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (sb_on) begin
                if (exp_q[exp_ptr].size() == 0) begin
                    check_val("sb_unexpected", 32'(out_payload), 32'hFFFF_FFFF);
                end else begin
                    check_val("sb_payload", 32'(out_payload), 32'(exp_q[exp_ptr][0]));
                    void'(exp_q[exp_ptr].pop_front());
                end
            end
        end
        if (v && rst_n) begin
            tgt = (exp_ptr + int'(d)) % NS;
            if (d == 2'd0)                   exp_ovf++;
            else if (exp_q[tgt].size() >= SD) exp_ovf++;
            else                             exp_q[tgt].push_back(pl);
        end
        if (tk && rst_n) begin
            if (tick_chk) check_val("tick_drained", 32'(exp_q[exp_ptr].size()), 32'd0);
            exp_q[exp_ptr].delete();
            exp_ptr = (exp_ptr + 1) % NS;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_tick_ptr", 32'(tick_ptr), 32'd0);
        check_val("rst_late", 32'(drop_late_cnt), 32'd0);
        check_val("rst_ovf", 32'(drop_ovf_cnt), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        model_clear();
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check_val("rst_in_ready_up", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [PW-1:0] pa [3];
        logic [PW-1:0] pl;
        int tgt;
        bit v;
        logic [1:0] d;

        // Test 1: reset
        do_reset();

        // Test 2: three packets with d=1 issued back-to-back from T+2
        pa[0] = 30'h0AAA_0001; pa[1] = 30'h0BBB_0002; pa[2] = 30'h0CCC_0003;
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1, pa[i], 1'b0, 1'b1);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b1);
        check_val("t2_ptr", 32'(tick_ptr), 32'd1);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t2_t1_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
            check_val("t2_valid", 32'(out_valid), 32'd1);
            check_val("t2_payload", 32'(out_payload), 32'(pa[i]));
        end
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t2_end_valid", 32'(out_valid), 32'd0);

        // Mid-operation reset must discard a buffered packet (lands in slot 2)
        cycle(1'b1, 2'd1, 30'h3DEAD_BEE, 1'b0, 1'b0);
        do_reset();

        // Test 3: d=0 drop plus one overflow into slot 2
        sb_on = 1'b1;
        cycle(1'b1, 2'd0, 30'h1234, 1'b0, 1'b1);
        for (int i = 0; i < SD + 1; i++) cycle(1'b1, 2'd2, PW'(i), 1'b0, 1'b1);
        check_val("t3_ovf", 32'(drop_ovf_cnt), cnt_exp(exp_ovf));
        check_val("t3_model_ovf", 32'(exp_ovf), 32'd2);
        hs_cnt = 0;
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b1);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b1);
        check_val("t3_ptr", 32'(tick_ptr), 32'd2);
        for (int i = 0; i < 400 && hs_cnt < SD; i++) cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t3_delivered", 32'(hs_cnt), 32'(SD));
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b1);
        check_val("t3_late", 32'(drop_late_cnt), 32'd0);
        check_val("t3_ptr3", 32'(tick_ptr), 32'd3);
        sb_on = 1'b0;

        // Test 4: 5 packets, stalled consumer, tick flushes 4, held entry survives
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, PW'(32'h100 + i), 1'b0, 1'b0);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check_val("t4_pre_valid", 32'(out_valid), 32'd1);
        check_val("t4_pre_payload", 32'(out_payload), 32'h100);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        exp_late = 4;
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check_val("t4_held_valid", 32'(out_valid), 32'd1);
        check_val("t4_held_payload", 32'(out_payload), 32'h100);
        check_val("t4_late", 32'(drop_late_cnt), cnt_exp(exp_late));
        check_val("t4_ptr", 32'(tick_ptr), 32'd1);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t4_accepted", 32'(out_valid), 32'd0);

        // Test 5: write d=1 together with the tick reaches the new slot
        cycle(1'b1, 2'd1, 30'h2A5A5A5, 1'b1, 1'b1);
        check_val("t5_ptr", 32'(tick_ptr), 32'd2);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t5_t1_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check_val("t5_valid", 32'(out_valid), 32'd1);
        check_val("t5_payload", 32'(out_payload), 32'h2A5A5A5);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1, 1'b1);
            check_val("t5_wrap_ptr", 32'(tick_ptr), 32'((3 + i) % NS));
        end
        check_val("t5_ovf", 32'(drop_ovf_cnt), cnt_exp(exp_ovf));

        // Randomized phase: periods long enough for each slot to drain fully
        for (int i = 0; i < NS; i++) exp_q[i].delete();
        sb_on = 1'b1;
        tick_chk = 1'b1;
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < 30; c++) begin
                v  = ($urandom_range(0, 2) == 0);
                d  = 2'($urandom_range(0, 3));
                pl = PW'($urandom);
                tgt = (exp_ptr + int'(d)) % NS;
                if (d != 2'd0 && exp_q[tgt].size() >= 8) v = 1'b0;
                cycle(v, d, pl, (c == 29), (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
            check_val("rnd_ptr", 32'(tick_ptr), 32'(exp_ptr));
        end
        check_val("rnd_ovf", 32'(drop_ovf_cnt), cnt_exp(exp_ovf));
        check_val("rnd_late", 32'(drop_late_cnt), cnt_exp(exp_late));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
